// File: rtl/uart_pkg.sv
// Shared constants and types for the AHB-Lite transmit-only UART.
package uart_pkg;

    localparam logic [1:0] REG_TXDATA = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_DIV    = 2'd2;

    localparam int unsigned STAT_FULL    = 0;
    localparam int unsigned STAT_EMPTY   = 1;
    localparam int unsigned STAT_ACTIVE  = 2;
    localparam int unsigned STAT_OVF     = 3;
    localparam int unsigned STAT_CNT_LSB = 4;

    localparam logic [1:0] HTRANS_IDLE   = 2'd0;
    localparam logic [1:0] HTRANS_BUSY   = 2'd1;
    localparam logic [1:0] HTRANS_NONSEQ = 2'd2;
    localparam logic [1:0] HTRANS_SEQ    = 2'd3;

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;

    localparam logic [15:0] MIN_DIV = 16'd2;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count; push is accepted when full only if a pop coincides.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic [WIDTH-1:0]         i_din,
    output logic [WIDTH-1:0]         o_dout,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_full,
    output logic                     o_empty
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [CW-1:0]    r_count;
    logic             w_pop_ok;
    logic             w_push_ok;

    assign o_full    = (r_count == CW'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign w_pop_ok  = i_pop & ~o_empty;
    assign w_push_ok = i_push & (~o_full | w_pop_ok);
    assign o_dout    = r_mem[r_rptr];
    assign o_count   = r_count;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push_ok) r_wptr <= r_wptr + AW'(1);
            if (w_pop_ok)  r_rptr <= r_rptr + AW'(1);
            r_count <= r_count + CW'(w_push_ok) - CW'(w_pop_ok);
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push_ok) r_mem[r_wptr] <= i_din;
    end

endmodule

// File: rtl/ahb_uart_tx.sv
// Zero-wait-state AHB-Lite slave: byte FIFO feeding an 8N1 LSB-first serial transmitter.
module ahb_uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned DIVISOR    = 868
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [ADDR_WIDTH-1:0] haddr,
    input  logic [DATA_WIDTH-1:0] hwdata,
    output logic [DATA_WIDTH-1:0] hrdata,
    input  logic                  hwrite,
    input  logic                  hsel,
    input  logic                  hmastlock,
    input  logic [1:0]            htrans,
    input  logic [3:0]            hprot,
    input  logic [2:0]            hburst,
    input  logic [2:0]            hsize,
    output logic                  hresp,
    output logic                  hready,
    output logic                  tx,
    output logic                  tx_busy
);
    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

    logic            r_valid;
    logic            r_write;
    logic [1:0]      r_addr;
    logic            r_ovf;
    logic [15:0]     r_div;
    tx_state_e       r_state;
    logic [7:0]      r_shift;
    logic [2:0]      r_bitidx;
    logic [15:0]     r_baud;
    logic            r_tx;

    logic            w_wr;
    logic            w_push;
    logic            w_pop;
    logic            w_full;
    logic            w_empty;
    logic [7:0]      w_dout;
    logic [CW-1:0]   w_count;
    logic [31:0]     w_cnt_ext;
    logic [3:0]      w_cnt_sat;
    logic            w_bit_end;
    logic            w_unused;

    assign hresp     = 1'b0;
    assign hready    = 1'b1;
    assign tx        = r_tx;
    assign tx_busy   = ~w_empty | (r_state != TX_IDLE);
    assign w_wr      = r_valid & r_write;
    assign w_push    = w_wr & (r_addr == REG_TXDATA);
    assign w_bit_end = (r_baud == 16'd0);
    assign w_pop     = ~w_empty & ((r_state == TX_IDLE) | ((r_state == TX_STOP) & w_bit_end));
    assign w_cnt_ext = 32'(w_count);
    assign w_cnt_sat = (w_cnt_ext > 32'd15) ? 4'hF : w_cnt_ext[3:0];
    assign w_unused  = ^{hmastlock, hprot, hburst, hsize, haddr[ADDR_WIDTH-1:4], haddr[1:0],
                         hwdata[DATA_WIDTH-1:16], w_cnt_ext[31:4]};

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (CLK),
        .i_rst   (RST),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_din   (hwdata[7:0]),
        .o_dout  (w_dout),
        .o_count (w_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_valid <= 1'b0;
            r_write <= 1'b0;
            r_addr  <= 2'd0;
            r_ovf   <= 1'b0;
            r_div   <= 16'(DIVISOR);
        end else begin
            r_valid <= hsel & htrans[1] & hready;
            r_write <= hwrite;
            r_addr  <= haddr[3:2];
            if (w_push & w_full & ~w_pop) begin
                r_ovf <= 1'b1;
            end else if (w_wr & (r_addr == REG_STATUS) & hwdata[STAT_OVF]) begin
                r_ovf <= 1'b0;
            end
            if (w_wr & (r_addr == REG_DIV)) begin
                r_div <= (hwdata[15:0] < MIN_DIV) ? MIN_DIV : hwdata[15:0];
            end
        end
    end

    always_comb begin
        hrdata = '0;
        if (r_valid & ~r_write) begin
            case (r_addr)
                REG_STATUS: begin
                    hrdata[STAT_FULL]            = w_full;
                    hrdata[STAT_EMPTY]           = w_empty;
                    hrdata[STAT_ACTIVE]          = (r_state != TX_IDLE);
                    hrdata[STAT_OVF]             = r_ovf;
                    hrdata[STAT_CNT_LSB +: 4]    = w_cnt_sat;
                end
                REG_DIV: hrdata[15:0] = r_div;
                default: ;
            endcase
        end
    end

    // The baud counter reloads from the live divisor at every bit boundary.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state  <= TX_IDLE;
            r_tx     <= 1'b1;
            r_shift  <= 8'd0;
            r_bitidx <= 3'd0;
            r_baud   <= 16'd0;
        end else begin
            if ((r_state != TX_IDLE) && !w_bit_end) r_baud <= r_baud - 16'd1;
            case (r_state)
                TX_IDLE: begin
                    if (w_pop) begin
                        r_shift <= w_dout;
                        r_tx    <= 1'b0;
                        r_baud  <= r_div - 16'd1;
                        r_state <= TX_START;
                    end
                end
                TX_START: begin
                    if (w_bit_end) begin
                        r_tx     <= r_shift[0];
                        r_shift  <= {1'b0, r_shift[7:1]};
                        r_bitidx <= 3'd0;
                        r_baud   <= r_div - 16'd1;
                        r_state  <= TX_DATA;
                    end
                end
                TX_DATA: begin
                    if (w_bit_end) begin
                        r_baud <= r_div - 16'd1;
                        if (r_bitidx == 3'd7) begin
                            r_tx    <= 1'b1;
                            r_state <= TX_STOP;
                        end else begin
                            r_tx     <= r_shift[0];
                            r_shift  <= {1'b0, r_shift[7:1]};
                            r_bitidx <= r_bitidx + 3'd1;
                        end
                    end
                end
                TX_STOP: begin
                    if (w_bit_end) begin
                        if (w_pop) begin
                            r_shift <= w_dout;
                            r_tx    <= 1'b0;
                            r_baud  <= r_div - 16'd1;
                            r_state <= TX_START;
                        end else begin
                            r_state <= TX_IDLE;
                        end
                    end
                end
                default: r_state <= TX_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ahb_uart_tx.sv
// Self-checking bench: bus transactions plus a frame-waveform reference derived from 8N1 rules.
module tb_ahb_uart_tx;
    import uart_pkg::*;

    localparam int unsigned DIV0  = 4;
    localparam int unsigned DEPTH = 8;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [31:0] haddr = '0;
    logic [31:0] hwdata = '0;
    logic [31:0] hrdata;
    logic        hwrite = 1'b0;
    logic        hsel = 1'b0;
    logic        hmastlock = 1'b0;
    logic [1:0]  htrans = HTRANS_IDLE;
    logic [3:0]  hprot = 4'd0;
    logic [2:0]  hburst = 3'd0;
    logic [2:0]  hsize = 3'd2;
    logic        hresp;
    logic        hready;
    logic        tx;
    logic        tx_busy;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [7:0]  wr_buf [16];

    ahb_uart_tx #(
        .ADDR_WIDTH (32),
        .DATA_WIDTH (32),
        .FIFO_DEPTH (DEPTH),
        .DIVISOR    (DIV0)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .haddr     (haddr),
        .hwdata    (hwdata),
        .hrdata    (hrdata),
        .hwrite    (hwrite),
        .hsel      (hsel),
        .hmastlock (hmastlock),
        .htrans    (htrans),
        .hprot     (hprot),
        .hburst    (hburst),
        .hsize     (hsize),
        .hresp     (hresp),
        .hready    (hready),
        .tx        (tx),
        .tx_busy   (tx_busy)
    );

    always #5 CLK = ~CLK;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic bus_cycle(input logic [1:0] trans, input logic wr, input logic [31:0] addr,
                             input logic [31:0] wdata, output logic [31:0] rdata);
        hsel   = 1'b1;
        htrans = trans;
        hwrite = wr;
        haddr  = addr;
        tick();
        hsel   = 1'b0;
        htrans = HTRANS_IDLE;
        hwrite = 1'b0;
        hwdata = wdata;
        rdata  = hrdata;
        tick();
        hwdata = '0;
    endtask

    task automatic ahb_write(input logic [31:0] addr, input logic [31:0] data);
        logic [31:0] d;
        bus_cycle(HTRANS_NONSEQ, 1'b1, addr, data, d);
    endtask

    task automatic read_check(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        logic [31:0] d;
        bus_cycle(HTRANS_NONSEQ, 1'b0, addr, 32'h0, d);
        check_eq(tag, d, exp);
    endtask

    // Pipelined NONSEQ writes to TXDATA: beat i's data phase overlaps beat i+1's address phase.
    task automatic write_burst(input int n);
        for (int i = 0; i < n; i++) begin
            hsel   = 1'b1;
            htrans = HTRANS_NONSEQ;
            hwrite = 1'b1;
            haddr  = 32'h0;
            hwdata = (i > 0) ? {24'h0, wr_buf[i-1]} : 32'h0;
            tick();
        end
        hsel   = 1'b0;
        htrans = HTRANS_IDLE;
        hwrite = 1'b0;
        hwdata = {24'h0, wr_buf[n-1]};
        tick();
        hwdata = '0;
    endtask

    task automatic rst_pulse();
        RST = 1'b1;
        tick();
        RST = 1'b0;
    endtask

    task automatic wait_fall(input int budget);
        int n = 0;
        while (tx !== 1'b0 && n < budget) begin
            tick();
            n++;
        end
        check_eq("tx_fall", {31'h0, tx}, 32'h0);
    endtask

    // Expected line level per cycle: start bit, 8 data bits LSB first, stop bit.
    task automatic check_frame(input logic [7:0] b, input int len0, input int lenr);
        logic lvl;
        int   len;
        for (int k = 0; k < 10; k++) begin
            lvl = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : b[k-1];
            len = (k == 0) ? len0 : lenr;
            for (int j = 0; j < len; j++) begin
                check_eq($sformatf("frame_%02h_bit%0d", b, k), {31'h0, tx}, {31'h0, lvl});
                tick();
            end
        end
    endtask

    initial begin
        logic [31:0] rd;
        int          lows;
        int          d;
        int          n;

        repeat (3) tick();
        RST = 1'b0;

        // Reset state
        check_eq("reset_tx", {31'h0, tx}, 32'h1);
        check_eq("reset_busy", {31'h0, tx_busy}, 32'h0);
        check_eq("hresp", {31'h0, hresp}, 32'h0);
        check_eq("hready", {31'h0, hready}, 32'h1);
        read_check("reset_status", 32'h4, 32'h2);
        read_check("reset_div", 32'h8, DIV0);
        read_check("txdata_read", 32'h0, 32'h0);
        read_check("reserved_read", 32'hC, 32'h0);

        // Single byte: latency and waveform
        wr_buf[0] = 8'h55;
        write_burst(1);
        check_eq("lat_e1_tx", {31'h0, tx}, 32'h1);
        tick();
        check_eq("lat_e2_tx", {31'h0, tx}, 32'h0);
        check_eq("busy_in_frame", {31'h0, tx_busy}, 32'h1);
        check_frame(8'h55, DIV0, DIV0);
        check_eq("busy_after_frame", {31'h0, tx_busy}, 32'h0);
        check_eq("idle_tx", {31'h0, tx}, 32'h1);

        // Three back-to-back frames; count is 2 just after the first pop
        wr_buf[0] = 8'h41;
        wr_buf[1] = 8'h42;
        wr_buf[2] = 8'h43;
        fork
            begin
                write_burst(3);
                read_check("count_after_pop", 32'h4, 32'h24);
            end
            begin
                wait_fall(20);
                for (int k = 0; k < 3; k++) check_frame(wr_buf[k], DIV0, DIV0);
                check_eq("busy_after_three", {31'h0, tx_busy}, 32'h0);
            end
        join

        // Overflow with the shifter stalled on a huge divisor
        ahb_write(32'h8, 32'hFFFF);
        for (int i = 0; i < 10; i++) wr_buf[i] = 8'($urandom);
        write_burst(10);
        read_check("ovf_status", 32'h4, 32'h8D);
        check_eq("ovf_tx_start", {31'h0, tx}, 32'h0);
        ahb_write(32'h4, 32'h7);
        read_check("status_ro_bits", 32'h4, 32'h8D);
        ahb_write(32'h4, 32'h8);
        read_check("ovf_cleared", 32'h4, 32'h85);
        rst_pulse();
        read_check("post_ovf_reset", 32'h4, 32'h2);

        // Divisor clamping and upper-bit masking
        ahb_write(32'h8, 32'h0);
        read_check("div0_clamp", 32'h8, 32'h2);
        ahb_write(32'h8, 32'h1);
        read_check("div1_clamp", 32'h8, 32'h2);
        ahb_write(32'h8, 32'h0001_2345);
        read_check("div_mask", 32'h8, 32'h2345);
        ahb_write(32'h8, DIV0);

        // Divisor change during the start bit: start keeps 4, later bits use 8
        wr_buf[0] = 8'hA5;
        write_burst(1);
        fork
            ahb_write(32'h8, 32'd8);
            begin
                tick();
                check_frame(8'hA5, DIV0, 8);
            end
        join
        check_eq("busy_after_divchg", {31'h0, tx_busy}, 32'h0);
        ahb_write(32'h8, DIV0);

        // Reset mid-frame abandons it and restores the divisor
        ahb_write(32'h8, 32'd3);
        wr_buf[0] = 8'hF0;
        write_burst(1);
        wait_fall(10);
        repeat (8) tick();
        rst_pulse();
        check_eq("midrst_tx", {31'h0, tx}, 32'h1);
        check_eq("midrst_busy", {31'h0, tx_busy}, 32'h0);
        read_check("midrst_status", 32'h4, 32'h2);
        read_check("midrst_div", 32'h8, DIV0);
        lows = 0;
        repeat (50) begin
            tick();
            if (tx !== 1'b1) lows++;
        end
        check_eq("abandoned_low_cycles", lows, 0);

        // BUSY/IDLE transfers are not accepted
        bus_cycle(HTRANS_BUSY, 1'b1, 32'h0, 32'h77, rd);
        check_eq("busy_trans_rdata", rd, 32'h0);
        bus_cycle(HTRANS_IDLE, 1'b0, 32'h8, 32'h0, rd);
        check_eq("idle_trans_rdata", rd, 32'h0);
        read_check("no_push_status", 32'h4, 32'h2);
        lows = 0;
        repeat (20) begin
            tick();
            if (tx !== 1'b1) lows++;
        end
        check_eq("no_push_line", lows, 0);

        // Randomized groups of bytes at random divisors
        for (int it = 0; it < 12; it++) begin
            d = $urandom_range(2, 5);
            n = $urandom_range(1, 3);
            ahb_write(32'h8, d);
            for (int i = 0; i < n; i++) wr_buf[i] = 8'($urandom);
            fork
                write_burst(n);
                begin
                    wait_fall(20);
                    for (int k = 0; k < n; k++) check_frame(wr_buf[k], d, d);
                end
            join
            check_eq("rand_busy_end", {31'h0, tx_busy}, 32'h0);
            read_check("rand_status_end", 32'h4, 32'h2);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
